// File: rtl/pipe_latch_if.sv
// Handshake/bus bundle for pipe_latch: advance qualifiers, flush, in/out payload, statistics.
// Latency: none, wires only.
// Backpressure: in_ready is driven by the latch; out_ready is driven by the consumer.
interface pipe_latch_if #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              en;
    logic              stall;
    logic [DEPTH-1:0]  flush_mask;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;
    logic [CNT_W-1:0]  occupancy;
    logic [31:0]       stall_cnt;
    logic [31:0]       flush_cnt;

    // Producer/consumer side of the latch
    modport master (
        output en, stall, flush_mask, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, occupancy, stall_cnt, flush_cnt
    );

    // Latch side
    modport slave (
        input  en, stall, flush_mask, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, occupancy, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_latch.sv
// Pipeline latch: DEPTH valid/data stages with global freeze, per-stage kill and statistics.
// Latency: DEPTH cycles from in_* to out_* while advancing; bubbles are kept, never collapsed.
// Backpressure: whole pipe advances only when en & !stall & (out_ready | !out_valid); in_ready mirrors that.
// Optional statistics counters are built when PIPE_LATCH_STATS_EN is defined; otherwise they read 0.
module pipe_latch #(
    parameter int DATA_W       = 32,
    parameter int DEPTH        = 1,
    parameter int ZERO_ON_KILL = 1
) (
    input  logic         CLK,
    input  logic         nRST,
    pipe_latch_if.slave  bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0]  r_vld;
    logic [DATA_W-1:0] r_dat [DEPTH];
    logic [CNT_W-1:0]  r_occ;

    logic              w_adv;
    logic [DEPTH-1:0]  w_src_vld;
    logic [DATA_W-1:0] w_src_dat [DEPTH];
    logic [DEPTH-1:0]  w_shf_vld;
    logic [DATA_W-1:0] w_shf_dat [DEPTH];
    logic [DEPTH-1:0]  w_nxt_vld;
    logic [DATA_W-1:0] w_nxt_dat [DEPTH];
    logic [CNT_W-1:0]  w_pop;

    // The whole pipe moves as one; a full output stage that is not consumed blocks everything.
    assign w_adv        = bus.en & ~bus.stall & (bus.out_ready | ~r_vld[DEPTH-1]);
    assign bus.in_ready = w_adv & nRST;

    // Each stage's candidate source: upstream input for stage 0, previous stage otherwise.
    always_comb begin
        w_src_vld = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_src_dat[i] = '0;
        end
        w_src_vld[0] = bus.in_valid;
        w_src_dat[0] = bus.in_data;
        for (int i = 1; i < DEPTH; i++) begin
            w_src_vld[i] = r_vld[i-1];
            w_src_dat[i] = r_dat[i-1];
        end
    end

    // Shift-or-hold first, then apply the kill mask on top, then count survivors.
    always_comb begin
        w_shf_vld = '0;
        w_nxt_vld = '0;
        w_pop     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_shf_vld[i] = w_adv ? w_src_vld[i] : r_vld[i];
            w_shf_dat[i] = w_adv ? w_src_dat[i] : r_dat[i];
            w_nxt_vld[i] = w_shf_vld[i] & ~bus.flush_mask[i];
            w_nxt_dat[i] = (bus.flush_mask[i] && (ZERO_ON_KILL != 0)) ? '0 : w_shf_dat[i];
            w_pop        = w_pop + CNT_W'(w_nxt_vld[i]);
        end
    end

    // Stage registers and occupancy; reset wins over advance and flush.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_vld <= '0;
            r_occ <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_dat[i] <= '0;
            end
        end else begin
            r_vld <= w_nxt_vld;
            r_occ <= w_pop;
            for (int i = 0; i < DEPTH; i++) begin
                r_dat[i] <= w_nxt_dat[i];
            end
        end
    end

    assign bus.out_valid = r_vld[DEPTH-1];
    assign bus.out_data  = r_dat[DEPTH-1];
    assign bus.occupancy = r_occ;

`ifdef PIPE_LATCH_STATS_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;
    logic [31:0] w_kill_num;

    // Number of live entries destroyed by the kill mask this cycle.
    always_comb begin
        w_kill_num = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_kill_num = w_kill_num + 32'(w_shf_vld[i] & bus.flush_mask[i]);
        end
    end

    // Free-running statistics, wrapping naturally at 2^32.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (bus.stall | ~bus.en) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            r_flush_cnt <= r_flush_cnt + w_kill_num;
        end
    end

    assign bus.stall_cnt = r_stall_cnt;
    assign bus.flush_cnt = r_flush_cnt;
`else
    assign bus.stall_cnt = '0;
    assign bus.flush_cnt = '0;
`endif
endmodule

// File: tb/tb_pipe_latch.sv
// Directed bench for pipe_latch: DEPTH=3 vector table, plus DEPTH=2 (data kept on kill) and DEPTH=1 sequences.
// Latency: checks outputs 1 time unit after each rising edge, in_ready before the edge.
// Backpressure: exercises stall, en=0, out_ready=0 and flush with and without advance.
module tb_pipe_latch;
`ifdef PIPE_LATCH_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic CLK;
    logic nRST;
    int   checks = 0;
    int   errors = 0;

    pipe_latch_if #(.DATA_W(32), .DEPTH(3)) b3 ();
    pipe_latch_if #(.DATA_W(32), .DEPTH(2)) b2 ();
    pipe_latch_if #(.DATA_W(32), .DEPTH(1)) b1 ();

    pipe_latch #(.DATA_W(32), .DEPTH(3), .ZERO_ON_KILL(1)) u3 (.CLK(CLK), .nRST(nRST), .bus(b3.slave));
    pipe_latch #(.DATA_W(32), .DEPTH(2), .ZERO_ON_KILL(0)) u2 (.CLK(CLK), .nRST(nRST), .bus(b2.slave));
    pipe_latch #(.DATA_W(32), .DEPTH(1), .ZERO_ON_KILL(1)) u1 (.CLK(CLK), .nRST(nRST), .bus(b1.slave));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        en;
        logic        st;
        logic [2:0]  fm;
        logic        iv;
        logic [31:0] id;
        logic        ordy;
        logic        x_rdy;
        logic        x_ov;
        logic [31:0] x_od;
        logic [1:0]  x_occ;
        logic [31:0] x_sc;
        logic [31:0] x_fc;
    } vec_t;

    vec_t tbl [26];

    function automatic vec_t mk(input logic en, input logic st, input logic [2:0] fm, input logic iv,
                                input logic [31:0] id, input logic ordy, input logic x_rdy,
                                input logic x_ov, input logic [31:0] x_od, input logic [1:0] x_occ,
                                input logic [31:0] x_sc, input logic [31:0] x_fc);
        vec_t v;
        v.en = en; v.st = st; v.fm = fm; v.iv = iv; v.id = id; v.ordy = ordy;
        v.x_rdy = x_rdy; v.x_ov = x_ov; v.x_od = x_od; v.x_occ = x_occ;
        v.x_sc = STATS ? x_sc : 32'd0;
        v.x_fc = STATS ? x_fc : 32'd0;
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s [%0d]: got %h want %h", nm, idx, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drv3(input logic en, input logic st, input logic [2:0] fm, input logic iv,
                        input logic [31:0] id, input logic ordy);
        b3.en = en; b3.stall = st; b3.flush_mask = fm;
        b3.in_valid = iv; b3.in_data = id; b3.out_ready = ordy;
    endtask

    localparam logic [31:0] A1 = 32'hA000_0001, A2 = 32'hA000_0002, A3 = 32'hA000_0003;
    localparam logic [31:0] B1 = 32'hB000_0001, B2 = 32'hB000_0002, B3 = 32'hB000_0003;
    localparam logic [31:0] C1 = 32'hC000_0001;
    localparam logic [31:0] D1 = 32'hD000_0001, D2 = 32'hD000_0002, D3 = 32'hD000_0003;
    localparam logic [31:0] E1 = 32'hE000_0001, F1 = 32'hF000_0001, G1 = 32'h6000_0001;
    localparam logic [31:0] P1 = 32'h1000_0001, P2 = 32'h1000_0002, P3 = 32'h1000_0003;
    localparam logic [31:0] Q1 = 32'h2000_0001, R1 = 32'h3000_0001, R2 = 32'h3000_0002, R3 = 32'h3000_0003;

    initial begin
        //                en st fm    iv id  ordy  rdy ov od  occ sc fc
        tbl[0]  = mk(1, 0, 3'b000, 1, A1, 1,  1, 0, 0,  1, 0, 0);
        tbl[1]  = mk(1, 0, 3'b000, 1, A2, 1,  1, 0, 0,  2, 0, 0);
        tbl[2]  = mk(1, 0, 3'b000, 1, A3, 1,  1, 1, A1, 3, 0, 0);
        tbl[3]  = mk(1, 0, 3'b000, 0, 0,  1,  1, 1, A2, 2, 0, 0);
        tbl[4]  = mk(1, 0, 3'b000, 0, 0,  1,  1, 1, A3, 1, 0, 0);
        tbl[5]  = mk(1, 0, 3'b000, 0, 0,  1,  1, 0, 0,  0, 0, 0);
        tbl[6]  = mk(1, 0, 3'b000, 1, B1, 1,  1, 0, 0,  1, 0, 0);
        tbl[7]  = mk(1, 0, 3'b000, 1, B2, 1,  1, 0, 0,  2, 0, 0);
        tbl[8]  = mk(1, 0, 3'b000, 1, B3, 1,  1, 1, B1, 3, 0, 0);
        tbl[9]  = mk(1, 1, 3'b000, 1, C1, 1,  0, 1, B1, 3, 1, 0);
        tbl[10] = mk(1, 1, 3'b000, 1, C1, 1,  0, 1, B1, 3, 2, 0);
        tbl[11] = mk(1, 1, 3'b000, 1, C1, 1,  0, 1, B1, 3, 3, 0);
        tbl[12] = mk(1, 1, 3'b000, 1, C1, 1,  0, 1, B1, 3, 4, 0);
        tbl[13] = mk(0, 0, 3'b000, 1, C1, 1,  0, 1, B1, 3, 5, 0);
        tbl[14] = mk(1, 0, 3'b000, 1, C1, 0,  0, 1, B1, 3, 5, 0);
        tbl[15] = mk(1, 0, 3'b011, 1, C1, 1,  1, 1, B2, 1, 5, 2);
        tbl[16] = mk(1, 1, 3'b100, 0, 0,  1,  0, 0, 0,  0, 6, 3);
        tbl[17] = mk(1, 0, 3'b000, 1, D1, 1,  1, 0, 0,  1, 6, 3);
        tbl[18] = mk(1, 0, 3'b000, 1, D2, 1,  1, 0, 0,  2, 6, 3);
        tbl[19] = mk(1, 0, 3'b000, 0, 0,  1,  1, 1, D1, 2, 6, 3);
        tbl[20] = mk(1, 0, 3'b000, 1, D3, 0,  0, 1, D1, 2, 6, 3);
        tbl[21] = mk(1, 0, 3'b000, 1, D3, 1,  1, 1, D2, 2, 6, 3);
        tbl[22] = mk(1, 0, 3'b000, 0, 0,  1,  1, 0, 0,  1, 6, 3);
        tbl[23] = mk(1, 0, 3'b000, 0, 0,  1,  1, 1, D3, 1, 6, 3);
        tbl[24] = mk(1, 0, 3'b000, 0, 0,  0,  0, 1, D3, 1, 6, 3);
        tbl[25] = mk(1, 0, 3'b001, 1, E1, 1,  1, 0, 0,  0, 6, 4);

        nRST = 1'b0;
        drv3(1, 0, 3'b000, 1, 32'h0, 1);
        b2.en = 1'b1; b2.stall = 1'b0; b2.flush_mask = '0; b2.in_valid = 1'b0; b2.in_data = '0; b2.out_ready = 1'b1;
        b1.en = 1'b1; b1.stall = 1'b0; b1.flush_mask = '0; b1.in_valid = 1'b0; b1.in_data = '0; b1.out_ready = 1'b1;

        // Reset state
        tick();
        tick();
        chk("rst_in_ready", 0, 32'(b3.in_ready), 32'd0);
        chk("rst_out_valid", 0, 32'(b3.out_valid), 32'd0);
        chk("rst_out_data", 0, b3.out_data, 32'd0);
        chk("rst_occupancy", 0, 32'(b3.occupancy), 32'd0);
        chk("rst_stall_cnt", 0, b3.stall_cnt, 32'd0);
        chk("rst_flush_cnt", 0, b3.flush_cnt, 32'd0);
        nRST = 1'b1;

        // DEPTH=3 vector table
        for (int i = 0; i < 26; i++) begin
            drv3(tbl[i].en, tbl[i].st, tbl[i].fm, tbl[i].iv, tbl[i].id, tbl[i].ordy);
            #1;
            chk("in_ready", i, 32'(b3.in_ready), 32'(tbl[i].x_rdy));
            tick();
            chk("out_valid", i, 32'(b3.out_valid), 32'(tbl[i].x_ov));
            chk("out_data", i, b3.out_data, tbl[i].x_od);
            chk("occupancy", i, 32'(b3.occupancy), 32'(tbl[i].x_occ));
            chk("stall_cnt", i, b3.stall_cnt, tbl[i].x_sc);
            chk("flush_cnt", i, b3.flush_cnt, tbl[i].x_fc);
        end

        // Reset mid-stream with a full pipe, then first entry after release
        for (int i = 0; i < 3; i++) begin
            drv3(1, 0, 3'b000, 1, F1 + 32'(i), 1);
            tick();
        end
        chk("full_occ", 0, 32'(b3.occupancy), 32'd3);
        nRST = 1'b0;
        drv3(1, 0, 3'b000, 1, 32'hDEAD_BEEF, 1);
        #1;
        chk("inrst_in_ready", 0, 32'(b3.in_ready), 32'd0);
        tick();
        chk("midrst_out_valid", 0, 32'(b3.out_valid), 32'd0);
        chk("midrst_occ", 0, 32'(b3.occupancy), 32'd0);
        chk("midrst_out_data", 0, b3.out_data, 32'd0);
        chk("midrst_stall_cnt", 0, b3.stall_cnt, 32'd0);
        chk("midrst_flush_cnt", 0, b3.flush_cnt, 32'd0);
        nRST = 1'b1;
        drv3(1, 0, 3'b000, 1, G1, 1);
        tick();
        chk("post_rst_ov1", 1, 32'(b3.out_valid), 32'd0);
        drv3(1, 0, 3'b000, 0, 32'h0, 1);
        tick();
        chk("post_rst_ov2", 2, 32'(b3.out_valid), 32'd0);
        tick();
        chk("post_rst_ov3", 3, 32'(b3.out_valid), 32'd1);
        chk("post_rst_od3", 3, b3.out_data, G1);

        // DEPTH=2: output backpressure without loss, then kill that keeps data
        b2.in_valid = 1'b1; b2.in_data = P1;
        tick();
        b2.in_data = P2;
        tick();
        chk("d2_ov", 0, 32'(b2.out_valid), 32'd1);
        chk("d2_od", 0, b2.out_data, P1);
        chk("d2_occ", 0, 32'(b2.occupancy), 32'd2);
        b2.out_ready = 1'b0; b2.in_data = P3;
        #1;
        chk("d2_bp_in_ready", 0, 32'(b2.in_ready), 32'd0);
        tick();
        chk("d2_hold_od", 1, b2.out_data, P1);
        tick();
        chk("d2_hold_od", 2, b2.out_data, P1);
        chk("d2_hold_occ", 2, 32'(b2.occupancy), 32'd2);
        b2.out_ready = 1'b1;
        #1;
        chk("d2_resume_in_ready", 0, 32'(b2.in_ready), 32'd1);
        tick();
        chk("d2_resume_od", 0, b2.out_data, P2);
        b2.in_valid = 1'b0; b2.in_data = '0;
        tick();
        chk("d2_resume_od", 1, b2.out_data, P3);
        chk("d2_resume_occ", 1, 32'(b2.occupancy), 32'd1);
        tick();
        chk("d2_drain_ov", 0, 32'(b2.out_valid), 32'd0);
        b2.in_valid = 1'b1; b2.in_data = Q1;
        tick();
        b2.in_valid = 1'b0; b2.in_data = '0; b2.flush_mask = 2'b10;
        tick();
        chk("d2_kill_ov", 0, 32'(b2.out_valid), 32'd0);
        chk("d2_kill_keep_od", 0, b2.out_data, Q1);
        chk("d2_kill_occ", 0, 32'(b2.occupancy), 32'd0);
        b2.flush_mask = '0;

        // DEPTH=1: plain registered latch
        b1.in_valid = 1'b1; b1.in_data = R1;
        #1;
        chk("d1_in_ready", 0, 32'(b1.in_ready), 32'd1);
        tick();
        chk("d1_ov", 0, 32'(b1.out_valid), 32'd1);
        chk("d1_od", 0, b1.out_data, R1);
        b1.out_ready = 1'b0; b1.in_data = R2;
        #1;
        chk("d1_bp_in_ready", 0, 32'(b1.in_ready), 32'd0);
        tick();
        chk("d1_hold_od", 0, b1.out_data, R1);
        b1.out_ready = 1'b1;
        tick();
        chk("d1_next_od", 0, b1.out_data, R2);
        b1.flush_mask = 1'b1; b1.in_data = R3;
        tick();
        chk("d1_kill_ov", 0, 32'(b1.out_valid), 32'd0);
        chk("d1_kill_od", 0, b1.out_data, 32'd0);
        chk("d1_kill_occ", 0, 32'(b1.occupancy), 32'd0);
        b1.flush_mask = 1'b0;

`ifdef PIPE_LATCH_STATS_EN
        // Counter wrap from all-ones
        drv3(1, 0, 3'b000, 0, 32'h0, 1);
        force u3.r_stall_cnt = 32'hFFFF_FFFF;
        #1;
        release u3.r_stall_cnt;
        drv3(1, 1, 3'b000, 0, 32'h0, 1);
        tick();
        chk("stall_cnt_wrap", 0, b3.stall_cnt, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipe_latch.md
PIPE_LATCH -- requirements
Module: pipe_latch

Interface
REQ-001 Parameter DATA_W, default 32, payload width in bits (1..512).
REQ-002 Parameter DEPTH, default 1, number of register stages (1..8).
REQ-003 Parameter ZERO_ON_KILL, default 1: 1 = a flushed stage's data is zeroed; 0 = data is retained and only valid is cleared.
REQ-004 CLK  in  1  single clock; all state changes on the rising edge.
REQ-005 nRST  in  1  reset, synchronous, active-low.
REQ-006 en  in  1  global advance qualifier (ihit/dhit-style); 0 freezes all stages.
REQ-007 stall  in  1  hazard freeze; 1 freezes all stages.
REQ-008 flush_mask  in  DEPTH  per-stage kill; bit i invalidates the entry landing in stage i.
REQ-009 in_valid  in  1  upstream entry present.
REQ-010 in_data  in  DATA_W  upstream payload.
REQ-011 in_ready  out  1  stage 0 accepts this cycle.
REQ-012 out_valid  out  1  valid bit of stage DEPTH-1.
REQ-013 out_data  out  DATA_W  payload of stage DEPTH-1.
REQ-014 out_ready  in  1  downstream consumes out_data when out_valid=1.
REQ-015 occupancy  out  $clog2(DEPTH+1)  count of valid stages.
REQ-016 stall_cnt  out  32  cycles frozen by stall or !en (statistics).
REQ-017 flush_cnt  out  32  valid entries killed by flush_mask (statistics).

Function
REQ-018 The block SHALL hold DEPTH stages, each consisting of a valid bit and a DATA_W data register, with stage 0 fed from in_*.
REQ-019 adv SHALL equal en & !stall & (out_ready | !out_valid), evaluated combinationally.
REQ-020 in_ready SHALL equal adv; in_ready SHALL NOT depend on in_valid.
REQ-021 When adv=1, stage i SHALL load stage i-1 (stage 0 loads in_valid/in_data) on the clock edge: one cycle per stage, for a total latency of DEPTH cycles.
REQ-022 When adv=0, every stage SHALL hold its contents unchanged, except as modified by flush (REQ-023).
REQ-023 flush_mask SHALL apply after the shift: the next valid bit of stage i SHALL be 0 whenever flush_mask[i]=1, regardless of adv, stall, or en.
REQ-024 With ZERO_ON_KILL=1, a killed stage SHALL load all-zero data; with ZERO_ON_KILL=0, its data SHALL follow REQ-021/022.
REQ-025 Bubbles (valid=0) SHALL shift like entries; the block SHALL NOT collapse bubbles.
REQ-026 occupancy SHALL be the registered popcount of all stage valid bits, updated in the same cycle as those bits.
REQ-027 With DEPTH=1, the block SHALL behave as a single ID/EX-style latch: out_* is registered in_*.
REQ-028 When out_valid=1 and out_ready=0, the block SHALL hold out_data stable until consumed or flushed.

Reset
REQ-029 On a rising CLK edge with nRST=0, all valid bits, all data registers, occupancy, stall_cnt and flush_cnt SHALL be cleared to 0.
REQ-030 Reset SHALL override adv and flush_mask; an entry in flight when reset is asserted SHALL be discarded.
REQ-031 While in reset, in_ready SHALL be driven 0.
REQ-032 On the first edge after nRST returns to 1, the block SHALL operate normally.

Configuration
REQ-033 Macro PIPE_LATCH_STATS_EN defined: stall_cnt SHALL increment by 1 each non-reset cycle with (stall | !en).
REQ-034 Macro PIPE_LATCH_STATS_EN defined: flush_cnt SHALL increment by the number of stages i whose flush_mask[i]=1 and whose would-be-loaded valid=1.
REQ-035 Both counters SHALL wrap modulo 2^32.
REQ-036 Macro PIPE_LATCH_STATS_EN undefined: stall_cnt and flush_cnt SHALL be tied to 0, no counter flops SHALL be synthesised, and the ports SHALL remain present.

Verification
REQ-037 DEPTH=3, en=1, out_ready=1; inject A1,A2,A3 on consecutive cycles -> out_valid rises 3 cycles after A1 and out_data is A1,A2,A3 on consecutive cycles; occupancy peaks at 3.
REQ-038 DEPTH=3, pipe full, stall=1 for 4 cycles -> in_ready=0, out_data constant; with STATS_EN, stall_cnt=4.
REQ-039 DEPTH=3, pipe full, flush_mask=3'b011 for 1 cycle with adv=1 -> next cycle: stage 2 holds the old stage-1 entry, stages 0 and 1 are invalid with zero data; occupancy=1; flush_cnt=2.
REQ-040 DEPTH=2, out_ready=0 with out_valid=1 -> in_ready=0, no entry is lost; raising out_ready resumes in-order delivery.
REQ-041 nRST=0 asserted mid-stream with occupancy=3 -> next edge: out_valid=0, occupancy=0, counters=0; first input after release appears at the output DEPTH cycles later.
REQ-042 stall_cnt preloaded to 0xFFFFFFFF via force, one stall cycle -> stall_cnt=0.
